// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencers (ld / ldi / st).
// Holds the sequencer state encoding, the IR opcode values and the ALU
// operation codes so every sequencer decodes the same numbers.
package ctrl_pkg;

  // Sequencer states, 6-bit encoding: IDLE=0, T0=1 .. T7=8.
  typedef enum logic [5:0] {
    S_IDLE = 6'd0,
    S_T0   = 6'd1,
    S_T1   = 6'd2,
    S_T2   = 6'd3,
    S_T3   = 6'd4,
    S_T4   = 6'd5,
    S_T5   = 6'd6,
    S_T6   = 6'd7,
    S_T7   = 6'd8
  } state_t;

  // IR[31:27] opcode values.
  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;

  // ALU operation select codes.
  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00100;

  // States in which the sequencer waits on the memory handshake.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_T0) || (s == S_T7);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting on mem_ready.
// Ports:
//   i_clk     - clock, rising edge
//   i_rst     - synchronous active-high reset
//   i_clr     - clear the count (held while outside a wait state, so the
//               count is zero on entry to any wait state)
//   i_inc     - one more cycle of waiting (wait state, mem_ready low)
//   o_expired - count has reached WAIT_MAX
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [7:0] r_count;
  logic       w_expired;

  assign w_expired = (r_count == 8'(WAIT_MAX));
  assign o_expired = w_expired;

  // Holding at WAIT_MAX keeps the counter from wrapping if the owner is
  // slow to react to the expired flag.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= 8'd0;
    end else if (i_inc && !w_expired) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/st_ctrl_unit.sv
// Hardwired control sequencer for the store instruction st Ra, C(Rb).
// Fetches the instruction, forms Rb + C via Y/ALU/Z, loads MDR from Ra and
// issues a memory Write.
// Ports:
//   Clock, Clear          - clock and synchronous active-high reset
//   start                 - begin one fetch+store sequence (seen in IDLE only)
//   IR_op                 - IR[31:27] from the datapath
//   mem_ready             - memory finished the current Read/Write this cycle
//   PCout .. ZLowout, OP  - datapath controls, Moore-decoded from state
//   busy                  - sequencer not in IDLE
//   done/illegal/timeout  - one-cycle result pulses in the first IDLE cycle
//   dbg_state             - current state encoding for observation
// Handshakes: start is a request accepted only in IDLE (no ready is
// returned; busy tells the requester it was taken). mem_ready is the
// memory's acknowledge of the Read (T0) or Write (T7) that is held asserted
// until mem_ready is seen high at a rising edge.
module st_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter logic [4:0] ST_OPCODE = OPC_ST,
  parameter logic [4:0] ADD_OP    = ALU_ADD,
  parameter int         WAIT_MAX  = 15
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       start,
  input  logic [4:0] IR_op,
  input  logic       mem_ready,
  output logic       PCout,
  output logic       MARin,
  output logic       MDRin,
  output logic       Read,
  output logic       Write,
  output logic       IncPC,
  output logic       MDRout,
  output logic       IRin,
  output logic       Gra,
  output logic       Grb,
  output logic       Rout,
  output logic       BAout,
  output logic       Yin,
  output logic       Cout,
  output logic       ZHighin,
  output logic       ZLowin,
  output logic       ZLowout,
  output logic [4:0] OP,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       timeout,
  output logic [5:0] dbg_state
);

  state_t r_state;
  logic   r_done;
  logic   r_illegal;
  logic   r_timeout;
  logic   w_in_wait;
  logic   w_expired;

  assign w_in_wait = is_mem_wait_state(r_state);

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .i_clk     (Clock),
    .i_rst     (Clear),
    .i_clr     (!w_in_wait),
    .i_inc     (w_in_wait && !mem_ready),
    .o_expired (w_expired)
  );

  // Main sequencer. mem_ready is checked before the expired flag so a
  // memory that answers in the last allowed cycle still completes.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: if (start) r_state <= S_T0;
        S_T0: begin
          if (mem_ready) begin
            r_state <= S_T1;
          end else if (w_expired) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end
        end
        S_T1: r_state <= S_T2;
        S_T2: r_state <= S_T3;
        S_T3: begin
          if (IR_op == ST_OPCODE) begin
            r_state <= S_T4;
          end else begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b1;
          end
        end
        S_T4: r_state <= S_T5;
        S_T5: r_state <= S_T6;
        S_T6: r_state <= S_T7;
        S_T7: begin
          if (mem_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_expired) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore control decode.
  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    IncPC   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ZHighin = 1'b0;
    ZLowin  = 1'b0;
    ZLowout = 1'b0;
    OP      = ALU_NOP;
    case (r_state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T1: IncPC = 1'b1;
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      S_T4: begin
        Cout    = 1'b1;
        OP      = ADD_OP;
        ZHighin = 1'b1;
        ZLowin  = 1'b1;
      end
      S_T5: begin
        ZLowout = 1'b1;
        MARin   = 1'b1;
      end
      // Read stays low so MDR loads Ra from the bus, not from memory.
      S_T6: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        MDRin = 1'b1;
      end
      S_T7: Write = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign illegal   = r_illegal;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_st_ctrl_unit.sv
module tb_st_ctrl_unit;
  import ctrl_pkg::*;

  logic       Clock;
  logic       Clear;
  logic       start;
  logic [4:0] IR_op;
  logic       mem_ready;
  logic       PCout, MARin, MDRin, Read, Write, IncPC, MDRout, IRin;
  logic       Gra, Grb, Rout, BAout, Yin, Cout, ZHighin, ZLowin, ZLowout;
  logic [4:0] OP;
  logic       busy, done, illegal, timeout;
  logic [5:0] dbg_state;

  logic [16:0] w_ctrl;
  logic [3:0]  w_flags;

  int total = 0;
  int bad   = 0;

  st_ctrl_unit dut (
    .Clock(Clock), .Clear(Clear), .start(start), .IR_op(IR_op),
    .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
    .IncPC(IncPC), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Rout(Rout), .BAout(BAout), .Yin(Yin),
    .Cout(Cout), .ZHighin(ZHighin), .ZLowin(ZLowin), .ZLowout(ZLowout),
    .OP(OP), .busy(busy), .done(done), .illegal(illegal), .timeout(timeout),
    .dbg_state(dbg_state)
  );

  // Bit order: PCout MARin MDRin Read Write IncPC MDRout IRin
  //            Gra Grb Rout BAout Yin Cout ZHighin ZLowin ZLowout
  assign w_ctrl  = {PCout, MARin, MDRin, Read, Write, IncPC, MDRout, IRin,
                    Gra, Grb, Rout, BAout, Yin, Cout, ZHighin, ZLowin, ZLowout};
  // {busy, done, illegal, timeout}
  assign w_flags = {busy, done, illegal, timeout};

  localparam logic [16:0] C_ZERO = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_T0   = 17'b1_1_1_1_0_0_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_T1   = 17'b0_0_0_0_0_1_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_T2   = 17'b0_0_0_0_0_0_1_1_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_T3   = 17'b0_0_0_0_0_0_0_0_0_1_0_1_1_0_0_0_0;
  localparam logic [16:0] C_T4   = 17'b0_0_0_0_0_0_0_0_0_0_0_0_0_1_1_1_0;
  localparam logic [16:0] C_T5   = 17'b0_1_0_0_0_0_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [16:0] C_T6   = 17'b0_0_1_0_0_0_0_0_1_0_1_0_0_0_0_0_0;
  localparam logic [16:0] C_T7   = 17'b0_0_0_0_1_0_0_0_0_0_0_0_0_0_0_0_0;

  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_BUSY = 4'b1000;
  localparam logic [3:0] F_DONE = 4'b0100;
  localparam logic [3:0] F_ILL  = 4'b0010;
  localparam logic [3:0] F_TO   = 4'b0001;

  localparam logic [4:0] OP_ST  = 5'b00010;
  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_NON = 5'b00000;

  typedef struct {
    logic        clr;
    logic        st;
    logic [4:0]  irop;
    logic        mr;
    logic [5:0]  e_state;
    logic [16:0] e_ctrl;
    logic [4:0]  e_op;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t tbl[$];

  // ---------------- clock ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic add(input logic clr, input logic st, input logic [4:0] irop,
                     input logic mr, input logic [5:0] es, input logic [16:0] ec,
                     input logic [4:0] eo, input logic [3:0] ef);
    vec_t v;
    v.clr = clr; v.st = st; v.irop = irop; v.mr = mr;
    v.e_state = es; v.e_ctrl = ec; v.e_op = eo; v.e_flags = ef;
    tbl.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one store from IDLE. mem_ready is held low for the first t0_low
  // cycles of T0 and the first t7_low cycles of T7. Stops at the first
  // IDLE cycle after start and reports what it saw there.
  task automatic run_store(input int t0_low, input int t7_low, input logic busy_start,
                           output int lat, output int t0_n, output int t7_n,
                           output logic [3:0] end_flags, output logic [16:0] end_ctrl);
    int cyc;
    lat = 0; t0_n = 0; t7_n = 0;
    end_flags = 4'hf; end_ctrl = '1;
    IR_op = OP_ST; mem_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    for (int k = 0; k < 100; k++) begin
      if (dbg_state == 6'(S_T0)) t0_n++;
      if (dbg_state == 6'(S_T7)) t7_n++;
      if (dbg_state == 6'(S_IDLE)) begin
        lat = cyc;
        end_flags = w_flags;
        end_ctrl = w_ctrl;
        break;
      end
      if (dbg_state == 6'(S_T0))      mem_ready = (t0_n > t0_low);
      else if (dbg_state == 6'(S_T7)) mem_ready = (t7_n > t7_low);
      else                            mem_ready = 1'b1;
      start = busy_start;
      step();
      cyc++;
    end
    start = 1'b0;
    mem_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int lat, t0_n, t7_n;
    logic [3:0]  ef;
    logic [16:0] ec;
    bit reached;

    Clear = 1'b1; start = 1'b0; IR_op = OP_ST; mem_ready = 1'b0;
    step();

    //   clr st  irop   mr  state         ctrl    OP      flags
    add(1, 0, OP_ST, 1, 6'(S_IDLE), C_ZERO, OP_NON, F_IDLE);
    add(0, 1, OP_ST, 0, 6'(S_T0),   C_T0,   OP_NON, F_BUSY);
    add(0, 0, OP_ST, 0, 6'(S_T0),   C_T0,   OP_NON, F_BUSY);
    add(0, 0, OP_ST, 1, 6'(S_T1),   C_T1,   OP_NON, F_BUSY);
    add(0, 1, OP_ST, 1, 6'(S_T2),   C_T2,   OP_NON, F_BUSY);  // start while busy
    add(0, 0, OP_ST, 1, 6'(S_T3),   C_T3,   OP_NON, F_BUSY);
    add(0, 0, OP_ST, 1, 6'(S_T4),   C_T4,   OP_ADD, F_BUSY);
    add(0, 0, OP_ST, 1, 6'(S_T5),   C_T5,   OP_NON, F_BUSY);
    add(0, 0, OP_ST, 1, 6'(S_T6),   C_T6,   OP_NON, F_BUSY);
    add(0, 0, OP_ST, 1, 6'(S_T7),   C_T7,   OP_NON, F_BUSY);
    add(0, 0, OP_ST, 0, 6'(S_T7),   C_T7,   OP_NON, F_BUSY);
    add(0, 0, OP_ST, 1, 6'(S_IDLE), C_ZERO, OP_NON, F_DONE);
    add(0, 1, OP_LD, 1, 6'(S_T0),   C_T0,   OP_NON, F_BUSY);  // start in done cycle
    add(0, 0, OP_LD, 1, 6'(S_T1),   C_T1,   OP_NON, F_BUSY);
    add(0, 0, OP_LD, 1, 6'(S_T2),   C_T2,   OP_NON, F_BUSY);
    add(0, 0, OP_LD, 1, 6'(S_T3),   C_T3,   OP_NON, F_BUSY);
    add(0, 0, OP_LD, 1, 6'(S_IDLE), C_ZERO, OP_NON, F_ILL);
    add(0, 0, OP_LD, 1, 6'(S_IDLE), C_ZERO, OP_NON, F_IDLE);

    foreach (tbl[i]) begin
      Clear = tbl[i].clr; start = tbl[i].st;
      IR_op = tbl[i].irop; mem_ready = tbl[i].mr;
      step();
      check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(tbl[i].e_state));
      check($sformatf("vec%0d_ctrl",  i), 32'(w_ctrl),    32'(tbl[i].e_ctrl));
      check($sformatf("vec%0d_op",    i), 32'(OP),        32'(tbl[i].e_op));
      check($sformatf("vec%0d_flags", i), 32'(w_flags),   32'(tbl[i].e_flags));
    end
    Clear = 1'b0; start = 1'b0; mem_ready = 1'b0; IR_op = OP_ST;
    step();

    // Nominal latency: done seen 9 cycles after the start edge.
    run_store(0, 0, 1'b0, lat, t0_n, t7_n, ef, ec);
    check("nom_latency", 32'(lat), 32'd9);
    check("nom_t0_len",  32'(t0_n), 32'd1);
    check("nom_t7_len",  32'(t7_n), 32'd1);
    check("nom_flags",   32'(ef), 32'(F_DONE));
    step();

    // Memory wait: 3 low cycles in T0, 5 in T7.
    run_store(3, 5, 1'b0, lat, t0_n, t7_n, ef, ec);
    check("wait_latency", 32'(lat), 32'd17);
    check("wait_t0_len",  32'(t0_n), 32'd4);
    check("wait_t7_len",  32'(t7_n), 32'd6);
    check("wait_flags",   32'(ef), 32'(F_DONE));
    step();

    // Timeout: mem_ready never comes in T7.
    run_store(0, 1000, 1'b0, lat, t0_n, t7_n, ef, ec);
    check("to_latency", 32'(lat), 32'd24);
    check("to_t7_len",  32'(t7_n), 32'd16);
    check("to_flags",   32'(ef), 32'(F_TO));
    check("to_ctrl",    32'(ec), 32'(C_ZERO));
    step();
    check("to_pulse_len", 32'(w_flags), 32'(F_IDLE));

    // mem_ready arriving in the same cycle the count hits 15 wins.
    run_store(0, 15, 1'b0, lat, t0_n, t7_n, ef, ec);
    check("edge_latency", 32'(lat), 32'd24);
    check("edge_t7_len",  32'(t7_n), 32'd16);
    check("edge_flags",   32'(ef), 32'(F_DONE));
    step();

    // start held high while busy does not stretch the sequence.
    run_store(0, 0, 1'b1, lat, t0_n, t7_n, ef, ec);
    check("busy_start_latency", 32'(lat), 32'd9);
    check("busy_start_flags",   32'(ef), 32'(F_DONE));
    step();

    // Clear in T6: next edge IDLE, nothing completes.
    IR_op = OP_ST; mem_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dbg_state == 6'(S_T6)) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    check("rst_reach_t6", 32'(reached), 32'd1);
    Clear = 1'b1;
    step();
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_ctrl",  32'(w_ctrl), 32'(C_ZERO));
    check("rst_op",    32'(OP), 32'(OP_NON));
    check("rst_flags", 32'(w_flags), 32'(F_IDLE));
    Clear = 1'b0;
    step();
    check("rst_after_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_after_flags", 32'(w_flags), 32'(F_IDLE));
    check("rst_after_write", 32'(Write), 32'd0);

    run_store(0, 0, 1'b0, lat, t0_n, t7_n, ef, ec);
    check("post_rst_latency", 32'(lat), 32'd9);
    check("post_rst_flags",   32'(ef), 32'(F_DONE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
